alu_reservation_station: RTL and testbench

- Tomasulo reservation station feeding the ALU; the issuing side of the ALU's calculate interface.
- Accepts decoded integer/branch/jump instructions from the dispatcher and holds them until both operands are known.
- Snoops the ALU and LSB common-data broadcasts to capture operands.
- Issues one ready instruction per cycle to the ALU with registered outputs; flushed by the ROB on misprediction.

---
 rtl/alu_reservation_station_pkg.sv | 69 ++++++
 rtl/alu_reservation_station_if.sv | 54 +++++
 rtl/alu_reservation_station_rs_priority_encoder.sv | 21 ++
 rtl/alu_reservation_station.sv | 123 ++++++++++++
 tb/tb_alu_reservation_station.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
package alu_reservation_station_pkg;

    localparam int RS_SIZE_CFG  = 16;
    localparam int RS_IDX_W_CFG = 4;
    localparam int DATA_W       = 32;
    localparam int TAG_W        = 4;
    localparam int OP_W         = 6;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    // Inner opcodes used by the decoder for the ALU class.
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd2;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              rs1_ready;
        logic [DATA_W-1:0] rs1val;
        logic [TAG_W-1:0]  rs1tag;
        logic              rs2_ready;
        logic [DATA_W-1:0] rs2val;
        logic [TAG_W-1:0]  rs2tag;
        logic [TAG_W-1:0]  dest;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1val;
        logic [DATA_W-1:0] rs2val;
        logic [TAG_W-1:0]  dest;
    } issue_t;

    // Capture a broadcast value for a waiting operand; the ALU bus wins a tie.
    function automatic operand_t snoop(
        input operand_t          cur,
        input logic [TAG_W-1:0]  tag,
        input logic              alu_sig,
        input logic [TAG_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_res,
        input logic              lsb_sig,
        input logic [TAG_W-1:0]  lsb_tag,
        input logic [DATA_W-1:0] lsb_res
    );
        operand_t res;
        res = cur;
        if (!cur.ready) begin
            if (alu_sig && alu_tag == tag) begin
                res.ready = 1'b1;
                res.val   = alu_res;
            end else if (lsb_sig && lsb_tag == tag) begin
                res.ready = 1'b1;
                res.val   = lsb_res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, broadcast, flush and ALU-issue signals of the reservation station.
interface alu_reservation_station_if;
    import alu_reservation_station_pkg::*;

    logic              dispatch_signal_in;
    logic [OP_W-1:0]   dispatch_op_in;
    logic [DATA_W-1:0] dispatch_imm_in;
    logic [DATA_W-1:0] dispatch_pc_in;
    logic              dispatch_rs1_ready_in;
    logic              dispatch_rs2_ready_in;
    logic [DATA_W-1:0] dispatch_rs1val_in;
    logic [DATA_W-1:0] dispatch_rs2val_in;
    logic [TAG_W-1:0]  dispatch_rs1tag_in;
    logic [TAG_W-1:0]  dispatch_rs2tag_in;
    logic [TAG_W-1:0]  dispatch_dest_in;
    logic              full_out;

    logic              alu_broadcast_signal_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [TAG_W-1:0]  alu_dest_tag_in;
    logic              lsb_broadcast_signal_in;
    logic [DATA_W-1:0] lsb_result_in;
    logic [TAG_W-1:0]  lsb_dest_tag_in;

    logic              rob_clear_signal_in;

    logic              alu_calculate_signal_out;
    logic [OP_W-1:0]   alu_op_out;
    logic [DATA_W-1:0] alu_imm_out;
    logic [DATA_W-1:0] alu_pc_out;
    logic [DATA_W-1:0] alu_rs1val_out;
    logic [DATA_W-1:0] alu_rs2val_out;
    logic [TAG_W-1:0]  alu_dest_out;

    modport master (
        output dispatch_signal_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
               dispatch_rs1_ready_in, dispatch_rs2_ready_in, dispatch_rs1val_in,
               dispatch_rs2val_in, dispatch_rs1tag_in, dispatch_rs2tag_in, dispatch_dest_in,
               alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
               lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in, rob_clear_signal_in,
        input  full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out, alu_pc_out,
               alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );

    modport slave (
        input  dispatch_signal_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
               dispatch_rs1_ready_in, dispatch_rs2_ready_in, dispatch_rs1val_in,
               dispatch_rs2val_in, dispatch_rs1tag_in, dispatch_rs2tag_in, dispatch_dest_in,
               alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
               lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in, rob_clear_signal_in,
        output full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out, alu_pc_out,
               alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );
endinterface

// File: rtl/alu_reservation_station_rs_priority_encoder.sv
// Lowest-set-bit priority encoder used for free-slot and issue-slot selection.
module rs_priority_encoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end
endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station that holds ALU instructions until their operands
// arrive on the common data buses and issues one ready entry per cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_CFG,
    parameter int RS_IDX_W = RS_IDX_W_CFG
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    alu_reservation_station_if.slave rs
);
    rs_entry_t            ent [RS_SIZE];
    logic [RS_SIZE-1:0]   valid_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic                 free_found;
    logic                 iss_found;
    logic [RS_IDX_W-1:0]  free_idx;
    logic [RS_IDX_W-1:0]  iss_idx;
    operand_t             wake1 [RS_SIZE];
    operand_t             wake2 [RS_SIZE];
    operand_t             disp1;
    operand_t             disp2;
    logic                 vld_p0;
    issue_t               iss_p0;

    // Per-entry occupancy/readiness and the operand values after this cycle's snoop.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid & ent[i].rs1_ready & ent[i].rs2_ready;
            wake1[i] = snoop('{ready: ent[i].rs1_ready, val: ent[i].rs1val}, ent[i].rs1tag,
                             rs.alu_broadcast_signal_in, rs.alu_dest_tag_in, rs.alu_result_in,
                             rs.lsb_broadcast_signal_in, rs.lsb_dest_tag_in, rs.lsb_result_in);
            wake2[i] = snoop('{ready: ent[i].rs2_ready, val: ent[i].rs2val}, ent[i].rs2tag,
                             rs.alu_broadcast_signal_in, rs.alu_dest_tag_in, rs.alu_result_in,
                             rs.lsb_broadcast_signal_in, rs.lsb_dest_tag_in, rs.lsb_result_in);
        end
    end

    // Incoming operands can be satisfied by a broadcast in the dispatch cycle itself.
    always_comb begin
        disp1 = snoop('{ready: rs.dispatch_rs1_ready_in, val: rs.dispatch_rs1val_in},
                      rs.dispatch_rs1tag_in,
                      rs.alu_broadcast_signal_in, rs.alu_dest_tag_in, rs.alu_result_in,
                      rs.lsb_broadcast_signal_in, rs.lsb_dest_tag_in, rs.lsb_result_in);
        disp2 = snoop('{ready: rs.dispatch_rs2_ready_in, val: rs.dispatch_rs2val_in},
                      rs.dispatch_rs2tag_in,
                      rs.alu_broadcast_signal_in, rs.alu_dest_tag_in, rs.alu_result_in,
                      rs.lsb_broadcast_signal_in, rs.lsb_dest_tag_in, rs.lsb_result_in);
    end

    rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
        .vec   (~valid_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_enc (
        .vec   (ready_vec),
        .found (iss_found),
        .idx   (iss_idx)
    );

    assign rs.full_out                 = ~free_found;
    assign rs.alu_calculate_signal_out = vld_p0;
    assign rs.alu_op_out               = iss_p0.op;
    assign rs.alu_imm_out              = iss_p0.imm;
    assign rs.alu_pc_out               = iss_p0.pc;
    assign rs.alu_rs1val_out           = iss_p0.rs1val;
    assign rs.alu_rs2val_out           = iss_p0.rs2val;
    assign rs.alu_dest_out             = iss_p0.dest;

    // Entry table update: wakeup, issue-select into the output stage, and dispatch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            vld_p0 <= 1'b0;
            iss_p0 <= '{op: '0, imm: ZERO_WORD, pc: ZERO_WORD,
                        rs1val: ZERO_WORD, rs2val: ZERO_WORD, dest: '0};
        end else if (rs.rob_clear_signal_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i].valid <= 1'b0;
            end
            vld_p0 <= 1'b0;
        end else if (!rdy_in) begin
            vld_p0 <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].valid) begin
                    ent[i].rs1_ready <= wake1[i].ready;
                    ent[i].rs1val    <= wake1[i].val;
                    ent[i].rs2_ready <= wake2[i].ready;
                    ent[i].rs2val    <= wake2[i].val;
                end
            end
            // ---- issue stage p0 boundary ----
            if (iss_found) begin
                vld_p0 <= 1'b1;
                iss_p0 <= '{op: ent[iss_idx].op, imm: ent[iss_idx].imm, pc: ent[iss_idx].pc,
                            rs1val: ent[iss_idx].rs1val, rs2val: ent[iss_idx].rs2val,
                            dest: ent[iss_idx].dest};
                ent[iss_idx].valid <= 1'b0;
            end else begin
                vld_p0 <= 1'b0;
            end
            if (rs.dispatch_signal_in && free_found) begin
                ent[free_idx] <= '{valid: 1'b1, op: rs.dispatch_op_in,
                                   imm: rs.dispatch_imm_in, pc: rs.dispatch_pc_in,
                                   rs1_ready: disp1.ready, rs1val: disp1.val,
                                   rs1tag: rs.dispatch_rs1tag_in,
                                   rs2_ready: disp2.ready, rs2val: disp2.val,
                                   rs2tag: rs.dispatch_rs2tag_in,
                                   dest: rs.dispatch_dest_in};
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed scoreboard bench for the ALU reservation station.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    alu_reservation_station_if rsif();

    alu_reservation_station dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .rs     (rsif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   b     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        rsif.dispatch_signal_in      = 1'b0;
        rsif.dispatch_op_in          = '0;
        rsif.dispatch_imm_in         = '0;
        rsif.dispatch_pc_in          = '0;
        rsif.dispatch_rs1_ready_in   = 1'b0;
        rsif.dispatch_rs2_ready_in   = 1'b0;
        rsif.dispatch_rs1val_in      = '0;
        rsif.dispatch_rs2val_in      = '0;
        rsif.dispatch_rs1tag_in      = '0;
        rsif.dispatch_rs2tag_in      = '0;
        rsif.dispatch_dest_in        = '0;
        rsif.alu_broadcast_signal_in = 1'b0;
        rsif.alu_result_in           = '0;
        rsif.alu_dest_tag_in         = '0;
        rsif.lsb_broadcast_signal_in = 1'b0;
        rsif.lsb_result_in           = '0;
        rsif.lsb_dest_tag_in         = '0;
        rsif.rob_clear_signal_in     = 1'b0;
    endtask

    // Every pulse must match the oldest outstanding expectation, including its cycle.
    task automatic monitor();
        exp_t e;
        if (rsif.alu_calculate_signal_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_issue", 32'(rsif.alu_calculate_signal_out), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("issue_cycle", cyc, e.cyc);
                chk("issue_op", 32'(rsif.alu_op_out), 32'(e.op));
                chk("issue_imm", rsif.alu_imm_out, e.imm);
                chk("issue_pc", rsif.alu_pc_out, e.pc);
                chk("issue_rs1val", rsif.alu_rs1val_out, e.v1);
                chk("issue_rs2val", rsif.alu_rs2val_out, e.v2);
                chk("issue_dest", 32'(rsif.alu_dest_out), 32'(e.dest));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        clear_pulses();
        monitor();
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                            input logic r1rdy, input logic [31:0] r1v, input logic [3:0] r1t,
                            input logic r2rdy, input logic [31:0] r2v, input logic [3:0] r2t,
                            input logic [3:0] dest);
        chk("dispatch_not_full", 32'(rsif.full_out), 32'd0);
        rsif.dispatch_signal_in    = 1'b1;
        rsif.dispatch_op_in        = op;
        rsif.dispatch_imm_in       = imm;
        rsif.dispatch_pc_in        = pc;
        rsif.dispatch_rs1_ready_in = r1rdy;
        rsif.dispatch_rs1val_in    = r1v;
        rsif.dispatch_rs1tag_in    = r1t;
        rsif.dispatch_rs2_ready_in = r2rdy;
        rsif.dispatch_rs2val_in    = r2v;
        rsif.dispatch_rs2tag_in    = r2t;
        rsif.dispatch_dest_in      = dest;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic [3:0] dest, input int at);
        exp_t e;
        e.op = op; e.imm = imm; e.pc = pc; e.v1 = v1; e.v2 = v2; e.dest = dest; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
        rsif.alu_broadcast_signal_in = 1'b1;
        rsif.alu_dest_tag_in         = tag;
        rsif.alu_result_in           = val;
    endtask

    task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
        rsif.lsb_broadcast_signal_in = 1'b1;
        rsif.lsb_dest_tag_in         = tag;
        rsif.lsb_result_in           = val;
    endtask

    initial begin
        clear_pulses();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset then idle
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_full", 32'(rsif.full_out), 32'd0);
            chk("idle_calc", 32'(rsif.alu_calculate_signal_out), 32'd0);
        end
        chk("rst_op", 32'(rsif.alu_op_out), 32'd0);
        chk("rst_imm", rsif.alu_imm_out, 32'd0);
        chk("rst_pc", rsif.alu_pc_out, 32'd0);
        chk("rst_rs1val", rsif.alu_rs1val_out, 32'd0);
        chk("rst_rs2val", rsif.alu_rs2val_out, 32'd0);
        chk("rst_dest", 32'(rsif.alu_dest_out), 32'd0);

        // both operands ready: pulse two cycles after dispatch
        dispatch(OP_ADD, 32'h0, 32'h1000, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        expect_issue(OP_ADD, 32'h0, 32'h1000, 32'd5, 32'd7, 4'd3, cyc + 2);
        tick();
        chk("add_no_early_pulse", 32'(rsif.alu_calculate_signal_out), 32'd0);
        tick();
        tick();
        chk("add_single_pulse", 32'(rsif.alu_calculate_signal_out), 32'd0);
        tick();

        // rs1 waits on tag 9; tag 8 must not wake it
        dispatch(OP_ADDI, 32'd4, 32'h1004, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 4'd2);
        tick();
        alu_bc(4'd8, 32'h55);
        tick();
        tick();
        alu_bc(4'd9, 32'h100);
        expect_issue(OP_ADDI, 32'd4, 32'h1004, 32'h100, 32'd0, 4'd2, cyc + 2);
        tick();
        tick();
        tick();

        // capture from the LSB bus in the dispatch cycle
        dispatch(OP_ADD, 32'h0, 32'h1008, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd5, 4'd4);
        lsb_bc(4'd5, 32'hDEAD);
        expect_issue(OP_ADD, 32'h0, 32'h1008, 32'd1, 32'hDEAD, 4'd4, cyc + 2);
        tick();
        tick();
        tick();

        // ALU bus wins when both buses carry the same tag
        dispatch(OP_ADD, 32'h0, 32'h100C, 1'b0, 32'd0, 4'd7, 1'b1, 32'd2, 4'd0, 4'd5);
        alu_bc(4'd7, 32'h11);
        lsb_bc(4'd7, 32'h22);
        expect_issue(OP_ADD, 32'h0, 32'h100C, 32'h11, 32'd2, 4'd5, cyc + 2);
        tick();
        tick();
        tick();

        // rdy low ignores broadcasts and dispatches
        dispatch(OP_ADD, 32'h0, 32'h1010, 1'b0, 32'd0, 4'd3, 1'b1, 32'd9, 4'd0, 4'd6);
        tick();
        rdy = 1'b0;
        alu_bc(4'd3, 32'h33);
        dispatch(OP_ADD, 32'h0, 32'h1014, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd7);
        tick();
        tick();
        chk("frozen_calc", 32'(rsif.alu_calculate_signal_out), 32'd0);
        rdy = 1'b1;
        tick();
        tick();
        alu_bc(4'd3, 32'h33);
        expect_issue(OP_ADD, 32'h0, 32'h1010, 32'h33, 32'd9, 4'd6, cyc + 2);
        tick();
        tick();
        tick();

        // fill all entries, then flush
        for (int i = 0; i < 16; i++) begin
            dispatch(OP_ADDI, 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 32'd0, 4'(i),
                     1'b1, 32'd0, 4'd0, 4'(i));
            tick();
        end
        chk("full_after_fill", 32'(rsif.full_out), 32'd1);
        rsif.rob_clear_signal_in = 1'b1;
        alu_bc(4'd0, 32'h1);
        tick();
        chk("full_after_clear", 32'(rsif.full_out), 32'd0);
        chk("calc_after_clear", 32'(rsif.alu_calculate_signal_out), 32'd0);
        for (int t = 0; t < 16; t++) begin
            alu_bc(4'(t), 32'hBEEF);
            tick();
        end
        tick();
        tick();

        // in-order issue of slots 0..2 with dispatches during the issue burst
        for (int k = 0; k < 3; k++) begin
            dispatch(OP_ADD, 32'h0, 32'h3000 + 32'(4 * k), 1'b0, 32'd0, 4'd10,
                     1'b1, 32'(k), 4'd0, 4'(k));
            tick();
        end
        b = cyc;
        alu_bc(4'd10, 32'h77);
        expect_issue(OP_ADD, 32'h0, 32'h3000, 32'h77, 32'd0, 4'd0, b + 2);
        expect_issue(OP_ADD, 32'h0, 32'h3004, 32'h77, 32'd1, 4'd1, b + 3);
        expect_issue(OP_ADDI, 32'd12, 32'h3200, 32'd3, 32'd4, 4'd9, b + 4);
        expect_issue(OP_ADD, 32'h0, 32'h3008, 32'h77, 32'd2, 4'd2, b + 5);
        expect_issue(OP_ADDI, 32'd8, 32'h3100, 32'd1, 32'd2, 4'd8, b + 6);
        tick();
        // slot 0 is still occupied while it is being issued, so this lands in slot 3
        dispatch(OP_ADDI, 32'd8, 32'h3100, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd8);
        tick();
        // slot 0 is free from this cycle and, being lowest, issues ahead of slot 2
        dispatch(OP_ADDI, 32'd12, 32'h3200, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd9);
        tick();

        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            tick();
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
